mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 l_req, l_rdwr, l_addr, l_len  in  1/1/32/5  load requester: request, 0=read/1=write, beat address, burst length.
REQ-005 s_req, s_rdwr, s_addr, s_len, s_urgent  in  1/1/32/5/1  store requester: same fields, plus a priority override.
REQ-006 l_gnt, s_gnt  out  1 each  requester owns the memory interface.
REQ-007 l_ack, s_ack  out  1 each  beat accepted for that requester this cycle.
REQ-008 if_en, if_rdwr, if_addr, if_len  out  1/1/32/5  memory interface enable, direction, address, burst length.
REQ-009 if_ready  in  1  memory interface accepts the current beat.
REQ-010 busy  out  1  any grant active.

Function
REQ-011 States SHALL be IDLE, GNT_L and GNT_S; at most one grant is asserted in any cycle.
REQ-012 Burst length encoding SHALL be l_len/s_len = N beats for N in 1..31, and 0 = 32 beats.
REQ-013 IDLE arbitration SHALL follow these rules:
- s_req & s_urgent -> GNT_S.
- Otherwise, only one request -> grant that requester.
- Both requests -> grant the requester not in last_served.
- Grant is visible the cycle after the request is sampled (1-cycle latency).
REQ-014 On grant, the block SHALL latch the winner's length into a 6-bit beat counter, set to 32 when the length is 0, and update last_served.
REQ-015 While granted, the block SHALL combinationally forward the owner's rdwr/addr to if_rdwr/if_addr, forward the latched length to if_len, and drive if_en = owner req.
REQ-016 A beat SHALL complete when if_en & if_ready; that cycle, the owner's ack = 1 and the counter decrements.
REQ-017 If the owner drops req mid-burst, the block SHALL deassert if_en, keep the grant, and freeze the counter until req returns (stall, no release).
REQ-018 On the last beat (counter = 1 and beat completes), the block SHALL re-arbitrate in the same cycle, per REQ-013 and excluding the just-finished owner's request that cycle:
- The other requester pending -> switch directly to the other grant state, with no idle bubble.
- Otherwise -> IDLE.
REQ-019 s_urgent asserted mid-burst of GNT_L SHALL NOT preempt; it takes effect at the next arbitration point.
REQ-020 With no grant, the block SHALL drive if_en = 0, acks = 0, and if_addr/if_rdwr/if_len = 0.
REQ-021 if_ready while if_en = 0 SHALL be ignored.
REQ-022 busy SHALL equal l_gnt | s_gnt.

Reset
REQ-023 On rst assertion, state SHALL go to IDLE immediately, with all grants, acks and if_en = 0, counter = 0, and last_served = store, so load wins the first tie.
REQ-024 Reset mid-burst SHALL abandon the burst with no completion ack; arbitration resumes from IDLE on the first clock after rst deasserts.

Structure
REQ-025 A shared package mem_arb_pkg SHALL hold the state enum, the requester-id enum (REQ_L, REQ_S), and the constant MAX_BURST = 32.
REQ-026 The beat counter (load, decrement on ack, last flag) SHALL be a sub-module named burst_counter; arbitration and muxing stay in mem_port_arbiter.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Load only: l_req, l_len=4, if_ready=1 -> l_gnt one cycle later, l_ack for exactly 4 cycles, then IDLE.
- Tie: l_req=s_req=1 from reset, lengths 2 -> load served first (2 acks), then s_gnt with no idle cycle between last l_ack and first s_ack.
- Urgent: s_req with s_urgent=1 and l_req together in IDLE -> s_gnt first; s_urgent raised during a load burst of 8 -> no preemption, store granted after the 8th l_ack.
- Stall: grant load, len=3; drop l_req after beat 1 for 5 cycles -> if_en=0, l_gnt held, counter frozen, 2 more acks after l_req returns.
- Len 0 and backpressure: s_len=0, if_ready toggling 1/0 -> exactly 32 s_acks, if_len=0 throughout.
- Reset mid-burst: rst pulse at beat 3 of 6 -> all outputs 0 asynchronously; after release, pending l_req granted from IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Burst length encoding: 1..31 beats literally, 0 means MAX_BURST beats.
package mem_arb_pkg;

    localparam int MAX_BURST = 32;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 5;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_L = 2'd1,
        GNT_S = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_L = 1'b0,
        REQ_S = 1'b1
    } req_id_e;

    function automatic logic [CNT_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
        return (len == '0) ? CNT_W'(MAX_BURST) : {1'b0, len};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-interface and status signals around the arbiter.
// master = requesters/memory side, slave = the arbiter itself.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              l_req;
    logic              l_rdwr;
    logic [ADDR_W-1:0] l_addr;
    logic [LEN_W-1:0]  l_len;
    logic              s_req;
    logic              s_rdwr;
    logic [ADDR_W-1:0] s_addr;
    logic [LEN_W-1:0]  s_len;
    logic              s_urgent;
    logic              l_gnt;
    logic              s_gnt;
    logic              l_ack;
    logic              s_ack;
    logic              if_en;
    logic              if_rdwr;
    logic [ADDR_W-1:0] if_addr;
    logic [LEN_W-1:0]  if_len;
    logic              if_ready;
    logic              busy;

    modport master (
        output l_req, l_rdwr, l_addr, l_len,
        output s_req, s_rdwr, s_addr, s_len, s_urgent,
        output if_ready,
        input  l_gnt, s_gnt, l_ack, s_ack,
        input  if_en, if_rdwr, if_addr, if_len, busy
    );

    modport slave (
        input  l_req, l_rdwr, l_addr, l_len,
        input  s_req, s_rdwr, s_addr, s_len, s_urgent,
        input  if_ready,
        output l_gnt, s_gnt, l_ack, s_ack,
        output if_en, if_rdwr, if_addr, if_len, busy
    );

endinterface

// File: rtl/burst_counter.sv
// Beats-remaining counter for the current burst: load on grant, count down per accepted beat.
// Load has priority so a back-to-back grant on the last beat starts the new burst cleanly.
module burst_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= len_to_beats(i_len);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between a load and a store requester; grant 1 cycle after request.
// Owner dropping req stalls the burst (grant held); if_ready is the only backpressure on beats.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    arb_state_e       r_state;
    arb_state_e       w_next;
    req_id_e          r_last;
    logic [LEN_W-1:0] r_len;

    logic             w_l_gnt;
    logic             w_s_gnt;
    logic             w_if_en;
    logic             w_beat;
    logic             w_done;
    logic             w_grant_l;
    logic             w_grant_s;
    logic             w_load;
    logic [LEN_W-1:0] w_load_len;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_last;

    assign w_l_gnt = (r_state == GNT_L);
    assign w_s_gnt = (r_state == GNT_S);
    assign w_if_en = (w_l_gnt & bus.l_req) | (w_s_gnt & bus.s_req);
    assign w_beat  = w_if_en & bus.if_ready;
    assign w_done  = w_beat & w_cnt_last;

    // On the last beat only the other requester is a candidate, so urgency is moot there.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.s_req && bus.s_urgent) begin
                    w_next = GNT_S;
                end else if (bus.l_req && bus.s_req) begin
                    w_next = (r_last == REQ_S) ? GNT_L : GNT_S;
                end else if (bus.l_req) begin
                    w_next = GNT_L;
                end else if (bus.s_req) begin
                    w_next = GNT_S;
                end
            end
            GNT_L: begin
                if (w_done) begin
                    w_next = bus.s_req ? GNT_S : IDLE;
                end
            end
            GNT_S: begin
                if (w_done) begin
                    w_next = bus.l_req ? GNT_L : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_grant_l  = (w_next == GNT_L) && (r_state != GNT_L);
    assign w_grant_s  = (w_next == GNT_S) && (r_state != GNT_S);
    assign w_load     = w_grant_l | w_grant_s;
    assign w_load_len = w_grant_l ? bus.l_len : bus.s_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= REQ_S;
            r_len   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_l) begin
                r_last <= REQ_L;
                r_len  <= bus.l_len;
            end else if (w_grant_s) begin
                r_last <= REQ_S;
                r_len  <= bus.s_len;
            end
        end
    end

    burst_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_len  (w_load_len),
        .i_dec  (w_beat),
        .o_cnt  (w_cnt),
        .o_last (w_cnt_last)
    );

    assign bus.l_gnt   = w_l_gnt;
    assign bus.s_gnt   = w_s_gnt;
    assign bus.busy    = w_l_gnt | w_s_gnt;
    assign bus.if_en   = w_if_en;
    assign bus.l_ack   = w_beat & w_l_gnt;
    assign bus.s_ack   = w_beat & w_s_gnt;
    assign bus.if_rdwr = w_l_gnt ? bus.l_rdwr : (w_s_gnt ? bus.s_rdwr : 1'b0);
    assign bus.if_addr = w_l_gnt ? bus.l_addr : (w_s_gnt ? bus.s_addr : '0);
    assign bus.if_len  = (w_l_gnt | w_s_gnt) ? r_len : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after the rising edge, outputs sampled 1ns later.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mem_port_arbiter_if bus();

    mem_port_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.l_req    = 1'b0;
        bus.l_rdwr   = 1'b0;
        bus.l_addr   = '0;
        bus.l_len    = '0;
        bus.s_req    = 1'b0;
        bus.s_rdwr   = 1'b0;
        bus.s_addr   = '0;
        bus.s_len    = '0;
        bus.s_urgent = 1'b0;
        bus.if_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        chk_eq("rst_l_gnt", 32'(bus.l_gnt), 32'd0);
        chk_eq("rst_s_gnt", 32'(bus.s_gnt), 32'd0);
        chk_eq("rst_if_en", 32'(bus.if_en), 32'd0);
        chk_eq("rst_busy",  32'(bus.busy),  32'd0);
        chk_eq("rst_cnt",   32'(u_dut.u_cnt.o_cnt), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int acks;
        int lenbad;
        n_cmp = 0;
        n_err = 0;

        // Load only, 4 beats
        do_reset();
        bus.l_req = 1'b1; bus.l_len = 5'd4; bus.l_addr = 32'h0000_0100; bus.if_ready = 1'b1;
        settle();
        chk_eq("lo_no_gnt_yet", 32'(bus.l_gnt), 32'd0);
        step();
        settle();
        chk_eq("lo_gnt",   32'(bus.l_gnt),  32'd1);
        chk_eq("lo_busy",  32'(bus.busy),   32'd1);
        chk_eq("lo_addr",  bus.if_addr,     32'h0000_0100);
        chk_eq("lo_len",   32'(bus.if_len), 32'd4);
        chk_eq("lo_ack1",  32'(bus.l_ack),  32'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            settle();
            chk_eq($sformatf("lo_ack%0d", i), 32'(bus.l_ack), 32'd1);
        end
        step();
        bus.l_req = 1'b0;
        settle();
        chk_eq("lo_idle_gnt",  32'(bus.l_gnt),  32'd0);
        chk_eq("lo_idle_ack",  32'(bus.l_ack),  32'd0);
        chk_eq("lo_idle_addr", bus.if_addr,     32'd0);
        chk_eq("lo_idle_len",  32'(bus.if_len), 32'd0);

        // Tie from reset: load first, then store with no bubble
        do_reset();
        bus.l_req = 1'b1; bus.l_len = 5'd2; bus.s_req = 1'b1; bus.s_len = 5'd2;
        bus.s_addr = 32'h0000_0200; bus.if_ready = 1'b1;
        step();
        settle();
        chk_eq("tie_l_gnt", 32'(bus.l_gnt), 32'd1);
        chk_eq("tie_l_ack1", 32'(bus.l_ack), 32'd1);
        step();
        settle();
        chk_eq("tie_l_ack2", 32'(bus.l_ack), 32'd1);
        chk_eq("tie_s_wait", 32'(bus.s_gnt), 32'd0);
        step();
        bus.l_req = 1'b0;
        settle();
        chk_eq("tie_s_gnt",  32'(bus.s_gnt), 32'd1);
        chk_eq("tie_s_ack1", 32'(bus.s_ack), 32'd1);
        chk_eq("tie_s_addr", bus.if_addr,    32'h0000_0200);
        step();
        settle();
        chk_eq("tie_s_ack2", 32'(bus.s_ack), 32'd1);
        step();
        bus.s_req = 1'b0;
        settle();
        chk_eq("tie_idle", 32'(bus.busy), 32'd0);

        // Urgent store beats load in IDLE
        do_reset();
        bus.l_req = 1'b1; bus.l_len = 5'd1; bus.s_req = 1'b1; bus.s_len = 5'd1;
        bus.s_urgent = 1'b1; bus.if_ready = 1'b1;
        step();
        settle();
        chk_eq("urg_s_gnt", 32'(bus.s_gnt), 32'd1);
        chk_eq("urg_s_ack", 32'(bus.s_ack), 32'd1);
        step();
        bus.s_req = 1'b0; bus.s_urgent = 1'b0;
        settle();
        chk_eq("urg_l_after", 32'(bus.l_gnt), 32'd1);
        chk_eq("urg_l_ack",   32'(bus.l_ack), 32'd1);
        step();
        bus.l_req = 1'b0;
        settle();
        chk_eq("urg_idle", 32'(bus.busy), 32'd0);

        // Urgent raised mid load burst of 8: no preemption
        bus.l_req = 1'b1; bus.l_len = 5'd8;
        step();
        for (int i = 0; i < 8; i++) begin
            settle();
            chk_eq($sformatf("np_l_ack%0d", i + 1), 32'(bus.l_ack), 32'd1);
            chk_eq($sformatf("np_s_gnt%0d", i + 1), 32'(bus.s_gnt), 32'd0);
            if (i == 0) begin
                bus.s_req = 1'b1; bus.s_urgent = 1'b1; bus.s_len = 5'd1;
            end
            step();
        end
        bus.l_req = 1'b0;
        settle();
        chk_eq("np_s_gnt", 32'(bus.s_gnt), 32'd1);
        chk_eq("np_s_ack", 32'(bus.s_ack), 32'd1);
        step();
        bus.s_req = 1'b0; bus.s_urgent = 1'b0;
        settle();
        chk_eq("np_idle", 32'(bus.busy), 32'd0);

        // Stall: owner drops req after beat 1 for 5 cycles
        do_reset();
        bus.l_req = 1'b1; bus.l_len = 5'd3; bus.if_ready = 1'b1;
        step();
        settle();
        chk_eq("st_ack1", 32'(bus.l_ack), 32'd1);
        step();
        bus.l_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk_eq($sformatf("st_en%0d", i),  32'(bus.if_en), 32'd0);
            chk_eq($sformatf("st_gnt%0d", i), 32'(bus.l_gnt), 32'd1);
            chk_eq($sformatf("st_ack%0d", i), 32'(bus.l_ack), 32'd0);
            chk_eq($sformatf("st_cnt%0d", i), 32'(u_dut.u_cnt.o_cnt), 32'd2);
            step();
        end
        bus.l_req = 1'b1;
        settle();
        chk_eq("st_en_back", 32'(bus.if_en), 32'd1);
        chk_eq("st_ack2",    32'(bus.l_ack), 32'd1);
        step();
        settle();
        chk_eq("st_ack3", 32'(bus.l_ack), 32'd1);
        step();
        bus.l_req = 1'b0;
        settle();
        chk_eq("st_idle", 32'(bus.l_gnt), 32'd0);

        // Length 0 = 32 beats with if_ready toggling
        do_reset();
        bus.s_req = 1'b1; bus.s_len = 5'd0; bus.s_rdwr = 1'b1; bus.s_addr = 32'hCAFE_0000;
        bus.if_ready = 1'b1;
        step();
        settle();
        chk_eq("l0_cnt",  32'(u_dut.u_cnt.o_cnt), 32'd32);
        chk_eq("l0_rdwr", 32'(bus.if_rdwr),       32'd1);
        chk_eq("l0_addr", bus.if_addr,            32'hCAFE_0000);
        acks   = 0;
        lenbad = 0;
        for (int c = 0; c < 100; c++) begin
            if (!bus.s_gnt) break;
            bus.if_ready = ((c % 2) == 0);
            settle();
            if (bus.s_ack) acks++;
            if (bus.if_len != 5'd0) lenbad++;
            step();
            if (acks == 32) break;
        end
        bus.s_req = 1'b0;
        settle();
        chk_eq("l0_acks",   32'(acks),   32'd32);
        chk_eq("l0_lenbad", 32'(lenbad), 32'd0);
        chk_eq("l0_idle",   32'(bus.s_gnt), 32'd0);

        // Asynchronous reset at beat 3 of 6
        do_reset();
        bus.l_req = 1'b1; bus.l_len = 5'd6; bus.if_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            settle();
            chk_eq($sformatf("rb_ack%0d", i), 32'(bus.l_ack), 32'd1);
        end
        rst = 1'b1;
        #1;
        chk_eq("rb_async_gnt",  32'(bus.l_gnt), 32'd0);
        chk_eq("rb_async_ack",  32'(bus.l_ack), 32'd0);
        chk_eq("rb_async_en",   32'(bus.if_en), 32'd0);
        chk_eq("rb_async_busy", 32'(bus.busy),  32'd0);
        step();
        rst = 1'b0;
        settle();
        chk_eq("rb_idle_after", 32'(bus.l_gnt), 32'd0);
        step();
        settle();
        chk_eq("rb_regrant", 32'(bus.l_gnt), 32'd1);
        chk_eq("rb_ack_new", 32'(bus.l_ack), 32'd1);
        chk_eq("rb_cnt_new", 32'(u_dut.u_cnt.o_cnt), 32'd6);
        bus.l_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
